// File: rtl/dfe_cic_pkg.sv
// Shared constants and helpers for the CIC decimator: accumulator sizing,
// decimation clamp and the output saturation limits.
package dfe_cic_pkg;

  localparam int DEC_SEL_CLAMP = 4;

  function automatic int acc_width(input int data_w, input int n_stages, input int max_dec_log2);
    return data_w + n_stages * max_dec_log2;
  endfunction

  function automatic longint sat_max(input int data_w);
    return (longint'(1) <<< (data_w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int data_w);
    return -(longint'(1) <<< (data_w - 1));
  endfunction

endpackage

// File: rtl/cic_decimator_if.sv
// Sample-stream and control bundle between the IIR chain, the CIC decimator and its consumer.
interface cic_decimator_if #(
  parameter int DATA_WIDTH = 16
) ();

  // valid_in/valid_out are one-cycle strobes with no backpressure: a sample
  // transfers on every rising edge where its valid is high.
  logic                         valid_in;
  logic signed [DATA_WIDTH-1:0] cic_in;
  logic                         bypass;
  logic [2:0]                   dec_sel;
  logic [1:0]                   gain_sel;
  logic signed [DATA_WIDTH-1:0] cic_out;
  logic                         valid_out;
  logic                         overflow;
  logic                         underflow;

  modport master (
    output valid_in, cic_in, bypass, dec_sel, gain_sel,
    input  cic_out, valid_out, overflow, underflow
  );

  modport slave (
    input  valid_in, cic_in, bypass, dec_sel, gain_sel,
    output cic_out, valid_out, overflow, underflow
  );

endinterface

// File: rtl/cic_integrator_stage.sv
// One wrapping two's-complement integrator of the CIC chain, with enable and synchronous clear.
module cic_integrator_stage #(
  parameter int ACC_W = 36
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_en,
  input  logic                    i_clr,
  input  logic signed [ACC_W-1:0] i_din,
  output logic signed [ACC_W-1:0] o_acc
);

  logic signed [ACC_W-1:0] r_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + i_din;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/cic_decimator.sv
// N-stage CIC decimator (M=1, R=2^dec_sel) with unity-DC-gain rescale, post gain and saturation.
// Define CIC_ROUND_EN for round-half-up on the rescale; default build truncates.
module cic_decimator
  import dfe_cic_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int DATA_FRAC    = 15,
  parameter int N_STAGES     = 5,
  parameter int MAX_DEC_LOG2 = DEC_SEL_CLAMP
) (
  input logic            clk,
  input logic            rst_n,
  cic_decimator_if.slave bus
);

  localparam int ACC_W = acc_width(DATA_WIDTH, N_STAGES, MAX_DEC_LOG2);
  localparam int SH_W  = ACC_W + 4;
  localparam int CNT_W = MAX_DEC_LOG2;
  localparam logic signed [SH_W-1:0] SAT_HI = SH_W'(sat_max(DATA_WIDTH));
  localparam logic signed [SH_W-1:0] SAT_LO = SH_W'(sat_min(DATA_WIDTH));

  if (DATA_FRAC >= DATA_WIDTH) begin : g_bad_frac
    $error("DATA_FRAC must be smaller than DATA_WIDTH");
  end

  logic [2:0]                   r_dec_sel;
  logic                         r_bypass;
  logic [CNT_W-1:0]             r_cnt;
  logic signed [ACC_W-1:0]      r_dly [N_STAGES];
  logic signed [DATA_WIDTH-1:0] r_cic_out;
  logic                         r_valid_out;
  logic                         r_overflow;
  logic                         r_underflow;

  logic [2:0]                   w_dsel;
  logic                         w_cfg_chg;
  logic                         w_clr;
  logic                         w_accept;
  logic                         w_last;
  logic                         w_fire;
  logic [CNT_W-1:0]             w_cnt_max;
  int                           w_shift;
  logic signed [ACC_W-1:0]      w_sext_in;
  logic signed [ACC_W-1:0]      w_int [N_STAGES];
  logic signed [ACC_W-1:0]      w_comb_in [N_STAGES];
  logic signed [ACC_W-1:0]      w_comb_res;
  logic signed [ACC_W:0]        w_rnd;
  logic signed [ACC_W:0]        w_ext;
  logic signed [ACC_W:0]        w_shr;
  logic signed [SH_W-1:0]       w_scaled;
  logic signed [DATA_WIDTH-1:0] w_sat;
  logic                         w_ovf;
  logic                         w_unf;

  assign w_dsel    = (bus.dec_sel > 3'(MAX_DEC_LOG2)) ? 3'(MAX_DEC_LOG2) : bus.dec_sel;
  assign w_cnt_max = CNT_W'((32'd1 << w_dsel) - 32'd1);
  assign w_shift   = N_STAGES * int'(w_dsel);

  // A rate or mode change restarts the filter from zero; bypass keeps it parked there.
  assign w_cfg_chg = (bus.dec_sel != r_dec_sel) || (bus.bypass != r_bypass);
  assign w_clr     = w_cfg_chg || bus.bypass;
  assign w_accept  = bus.valid_in && !w_clr;
  assign w_last    = (r_cnt == w_cnt_max);
  assign w_fire    = w_accept && w_last;
  assign w_sext_in = {{(ACC_W - DATA_WIDTH){bus.cic_in[DATA_WIDTH-1]}}, bus.cic_in};

  for (genvar k = 0; k < N_STAGES; k++) begin : g_int
    if (k == 0) begin : g_first
      cic_integrator_stage #(.ACC_W(ACC_W)) u_stage (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_accept),
        .i_clr (w_clr),
        .i_din (w_sext_in),
        .o_acc (w_int[k])
      );
    end else begin : g_next
      cic_integrator_stage #(.ACC_W(ACC_W)) u_stage (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_accept),
        .i_clr (w_clr),
        .i_din (w_int[k-1]),
        .o_acc (w_int[k])
      );
    end
  end

  always_comb begin
    logic signed [ACC_W-1:0] v;
    v = w_int[N_STAGES-1];
    for (int k = 0; k < N_STAGES; k++) begin
      w_comb_in[k] = v;
      v = v - r_dly[k];
    end
    w_comb_res = v;
  end

`ifdef CIC_ROUND_EN
  assign w_rnd = (w_shift > 0) ? ((ACC_W+1)'(1) << (w_shift - 1)) : '0;
`else
  assign w_rnd = '0;
`endif

  // One guard bit keeps the rounding add from wrapping; three more absorb the x8 gain.
  always_comb begin
    w_ext    = {w_comb_res[ACC_W-1], w_comb_res} + w_rnd;
    w_shr    = w_ext >>> w_shift;
    w_scaled = {{3{w_shr[ACC_W]}}, w_shr} <<< bus.gain_sel;
    w_sat    = w_scaled[DATA_WIDTH-1:0];
    w_ovf    = 1'b0;
    w_unf    = 1'b0;
    if (w_scaled > SAT_HI) begin
      w_sat = SAT_HI[DATA_WIDTH-1:0];
      w_ovf = 1'b1;
    end else if (w_scaled < SAT_LO) begin
      w_sat = SAT_LO[DATA_WIDTH-1:0];
      w_unf = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dec_sel <= '0;
      r_bypass  <= 1'b0;
      r_cnt     <= '0;
      for (int k = 0; k < N_STAGES; k++) r_dly[k] <= '0;
    end else begin
      r_dec_sel <= bus.dec_sel;
      r_bypass  <= bus.bypass;
      if (w_clr) begin
        r_cnt <= '0;
        for (int k = 0; k < N_STAGES; k++) r_dly[k] <= '0;
      end else if (w_accept) begin
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        if (w_last) begin
          for (int k = 0; k < N_STAGES; k++) r_dly[k] <= w_comb_in[k];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cic_out   <= '0;
      r_valid_out <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_valid_out <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      if (bus.bypass && !w_cfg_chg) begin
        r_valid_out <= bus.valid_in;
        if (bus.valid_in) r_cic_out <= bus.cic_in;
      end else if (w_fire) begin
        r_valid_out <= 1'b1;
        r_cic_out   <= w_sat;
        r_overflow  <= w_ovf;
        r_underflow <= w_unf;
      end
    end
  end

  assign bus.cic_out   = r_cic_out;
  assign bus.valid_out = r_valid_out;
  assign bus.overflow  = r_overflow;
  assign bus.underflow = r_underflow;

endmodule

// File: tb/tb_cic_decimator.sv
// Directed bench for cic_decimator: settled-value vector table plus reset, rate-change and impulse sequences.
module tb_cic_decimator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cic_decimator_if #(.DATA_WIDTH(16)) bus ();

  cic_decimator #(
    .DATA_WIDTH   (16),
    .DATA_FRAC    (15),
    .N_STAGES     (5),
    .MAX_DEC_LOG2 (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        byp;
    logic [2:0]  dec;
    logic [1:0]  gain;
    logic [15:0] din;
    int          n;
    int          settle;
    logic [15:0] exp_out;
    logic        exp_ovf;
    logic        exp_unf;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  int          m_cnt = 0;
  logic [2:0]  cur_dec = 3'd0;
  logic        cur_byp = 1'b0;
  logic [15:0] exp_q[$];
  vec_t        vecs[14];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  function automatic int rate(input logic [2:0] d);
    return 1 << ((d > 3'd4) ? 4 : int'(d));
  endfunction

  task automatic cycle(input logic v, input logic [15:0] d);
    bus.valid_in = v;
    bus.cic_in   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic byp, input logic [2:0] dec, input logic [1:0] gain);
    bus.gain_sel = gain;
    if (byp != cur_byp || dec != cur_dec) begin
      bus.bypass  = byp;
      bus.dec_sel = dec;
      cycle(1'b0, 16'h0);
      check("cfg_chg_valid", {15'b0, bus.valid_out}, 16'h0);
      cur_byp = byp;
      cur_dec = dec;
      m_cnt   = 0;
    end
  endtask

  task automatic send(input logic [15:0] d, output logic fired);
    logic exp_v;
    if ($urandom_range(0, 3) == 0) begin
      cycle(1'b0, 16'h0);
      check("idle_valid", {15'b0, bus.valid_out}, 16'h0);
    end
    exp_v = cur_byp || (m_cnt == rate(cur_dec) - 1);
    cycle(1'b1, d);
    check("valid_out", {15'b0, bus.valid_out}, {15'b0, exp_v});
    if (cur_byp) check("byp_data", bus.cic_out, d);
    else m_cnt = (m_cnt == rate(cur_dec) - 1) ? 0 : m_cnt + 1;
    fired = exp_v;
  endtask

  task automatic run_impulse(input logic [15:0] amp);
    logic fired;
    set_cfg(1'b0, 3'd0, 2'd0);
    set_cfg(1'b0, 3'd1, 2'd0);
    for (int i = 0; i < 16; i++) begin
      send((i == 0) ? amp : 16'h0, fired);
      if (fired) begin
        if (exp_q.size() > 0) begin
          check("impulse_out", bus.cic_out, exp_q.pop_front());
        end else begin
          checks++;
          failures++;
          $display("FAIL impulse_extra: got 0x%04h expected no output", bus.cic_out);
        end
      end
    end
    check("impulse_drain", 16'(exp_q.size()), 16'h0);
    exp_q.delete();
  endtask

  initial begin
    logic fired;
    int   nout;
    int   settle;
    logic last_ovf;
    logic last_unf;

    //          byp  dec   gain  din       n    settle exp       ovf   unf
    vecs[0]  = '{1'b0, 3'd2, 2'd0, 16'h4000, 32,  6, 16'h4000, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 3'd2, 2'd0, 16'hC000, 32,  0, 16'hC000, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 3'd1, 2'd2, 16'h4000, 24,  0, 16'h7FFF, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 3'd1, 2'd2, 16'hC000, 24,  0, 16'h8000, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 3'd1, 2'd1, 16'h2000, 24,  0, 16'h4000, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 3'd1, 2'd3, 16'hF000, 24,  0, 16'h8000, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 3'd1, 2'd3, 16'h0FFF, 24,  0, 16'h7FF8, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 3'd1, 2'd3, 16'h1000, 24,  0, 16'h7FFF, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 3'd0, 2'd0, 16'h0123, 12,  6, 16'h0123, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 3'd7, 2'd0, 16'h1000, 112, 6, 16'h1000, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 3'd3, 2'd3, 16'h0800, 64,  0, 16'h4000, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 3'd3, 2'd0, 16'h0800, 64,  1, 16'h0800, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 3'd3, 2'd0, 16'h1234, 4,   1, 16'h1234, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 3'd2, 2'd0, 16'h4000, 32,  6, 16'h4000, 1'b0, 1'b0};

    bus.valid_in = 1'b0;
    bus.cic_in   = 16'h0;
    bus.bypass   = 1'b0;
    bus.dec_sel  = 3'd0;
    bus.gain_sel = 2'd0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_cic_out", bus.cic_out, 16'h0);
    check("rst_valid", {15'b0, bus.valid_out}, 16'h0);
    check("rst_flags", {14'b0, bus.overflow, bus.underflow}, 16'h0);
    rst_n = 1'b1;

    for (int r = 0; r < 14; r++) begin
      set_cfg(vecs[r].byp, vecs[r].dec, vecs[r].gain);
      nout     = 0;
      last_ovf = 1'b0;
      last_unf = 1'b0;
      settle   = (vecs[r].settle > 0) ? vecs[r].settle
               : (vecs[r].byp ? vecs[r].n : vecs[r].n / rate(vecs[r].dec));
      for (int i = 0; i < vecs[r].n; i++) begin
        send(vecs[r].din, fired);
        if (fired) begin
          nout++;
          last_ovf = bus.overflow;
          last_unf = bus.underflow;
          if (nout >= settle) begin
            check($sformatf("vec%0d_out", r), bus.cic_out, vecs[r].exp_out);
            check($sformatf("vec%0d_flags", r), {14'b0, last_ovf, last_unf},
                  {14'b0, vecs[r].exp_ovf, vecs[r].exp_unf});
          end
        end
      end
    end

    // Asynchronous reset right after an output strobe, then a fresh R=4 frame.
    for (int i = 0; i < 4; i++) send(16'h4000, fired);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_out", bus.cic_out, 16'h0);
    check("async_rst_valid", {15'b0, bus.valid_out}, 16'h0);
    check("async_rst_flags", {14'b0, bus.overflow, bus.underflow}, 16'h0);
    @(posedge clk);
    #1;
    check("rst_hold_valid", {15'b0, bus.valid_out}, 16'h0);
    rst_n   = 1'b1;
    cur_dec = 3'd0;
    cur_byp = 1'b0;
    set_cfg(1'b0, 3'd2, 2'd0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 16'h4000);
      check("post_rst_valid", {15'b0, bus.valid_out}, {15'b0, (i == 3)});
    end

    // Rate change 4 -> 8 mid-frame; the change-cycle sample is dropped.
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 16'h4000);
      check("pre_chg_valid", {15'b0, bus.valid_out}, {15'b0, (i == 3)});
    end
    bus.dec_sel = 3'd3;
    cycle(1'b1, 16'h4000);
    check("rate_chg_drop", {15'b0, bus.valid_out}, 16'h0);
    cur_dec = 3'd3;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 16'h4000);
      check("rate_chg_valid", {15'b0, bus.valid_out}, {15'b0, (i == 7)});
    end
    m_cnt = 0;

    // Impulse responses at R=2: raw comb outputs are a, 10a, 5a scaled by 2^-5.
    for (int i = 0; i < 8; i++) exp_q.push_back(16'h0000);
    run_impulse(16'h0001);
`ifdef CIC_ROUND_EN
    exp_q = '{16'h0000, 16'h0000, 16'h0001, 16'h0005, 16'h0003, 16'h0000, 16'h0000, 16'h0000};
`else
    exp_q = '{16'h0000, 16'h0000, 16'h0000, 16'h0005, 16'h0002, 16'h0000, 16'h0000, 16'h0000};
`endif
    run_impulse(16'h0010);
`ifdef CIC_ROUND_EN
    exp_q = '{16'h0000, 16'h0000, 16'h0000, 16'hFFFB, 16'hFFFE, 16'h0000, 16'h0000, 16'h0000};
`else
    exp_q = '{16'h0000, 16'h0000, 16'hFFFF, 16'hFFFB, 16'hFFFD, 16'h0000, 16'h0000, 16'h0000};
`endif
    run_impulse(16'hFFF0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cic_decimator.md
CIC_DECIMATOR -- requirements
Module: cic_decimator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, sample width (signed, Q1.15 with DATA_FRAC).
REQ-002 SHALL have parameter DATA_FRAC, default 15, fractional bits of cic_in/cic_out.
REQ-003 SHALL have parameter N_STAGES, default 5, integrator/comb order (differential delay M=1).
REQ-004 SHALL have parameter MAX_DEC_LOG2, default 4, largest decimation 2^4=16.
REQ-005 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-007 SHALL have port valid_in, input, 1, input sample strobe from IIR chain valid_out.
REQ-008 SHALL have port cic_in, input, DATA_WIDTH, signed sample from IIR chain iir_out.
REQ-009 SHALL have port bypass, input, 1, 1 = pass-through, no decimation.
REQ-010 SHALL have port dec_sel, input, 3, R = 2^dec_sel; values 5..7 treated as 4.
REQ-011 SHALL have port gain_sel, input, 2, post-scale left shift 0..3 (x1..x8).
REQ-012 SHALL have port cic_out, output, DATA_WIDTH, signed decimated sample.
REQ-013 SHALL have port valid_out, output, 1, one-cycle strobe per output sample.
REQ-014 SHALL have ports overflow and underflow, output, 1 each, saturation pulses aligned with valid_out.

Function
REQ-015 SHALL use accumulator width ACC_W = DATA_WIDTH + N_STAGES*MAX_DEC_LOG2 (36), two's-complement wrap in integrators and combs.
REQ-016 On valid_in: int[0] += sext(cic_in); int[k] += old int[k-1] for k>=1; idle cycles hold all state.
REQ-017 SHALL count accepted valid_in 0..R-1; the acceptance at count R-1 wraps the count to 0 and fires the comb chain on old int[N_STAGES-1].
REQ-018 Comb k: y = x - d[k], d[k] <= x, updated only on firing.
REQ-019 Comb result SHALL be arithmetic right-shifted by N_STAGES*dec_sel (unity DC gain), then left-shifted by gain_sel, then saturated to DATA_WIDTH.
REQ-020 Saturation: result > 0x7FFF -> 0x7FFF with overflow=1; result < 0x8000 -> 0x8000 with underflow=1; flags otherwise 0.
REQ-021 valid_out, cic_out and flags SHALL register exactly 1 cycle after the firing valid_in; cic_out holds between strobes.
REQ-022 dec_sel or bypass differing from its registered copy SHALL synchronously clear integrators, combs and counter that cycle; valid_in that cycle is dropped.
REQ-023 bypass=1: cic_out <= cic_in, valid_out <= valid_in, 1-cycle latency, flags 0, CIC state held clear.
REQ-024 gain_sel changes SHALL take effect on the next output without clearing state.

Reset
REQ-025 rst_n low SHALL immediately clear cic_out, valid_out, overflow, underflow, counter, integrators, combs and registered dec_sel/bypass copies to 0.
REQ-026 Reset mid-stream SHALL discard partial decimation; first output after release needs R fresh valid_in.

Configuration
REQ-027 Macro CIC_ROUND_EN defined: add 2^(shift-1) before right-shift (round half-up; none when shift=0).
REQ-028 CIC_ROUND_EN undefined: plain truncation (floor) on right-shift.

Structure
REQ-029 Package dfe_cic_pkg SHALL hold ACC_W function, dec_sel clamp constant (MAX_DEC_LOG2) and saturation limit constants.
REQ-030 Sub-module cic_integrator_stage (one ACC_W accumulator with enable and clear) SHALL be instantiated N_STAGES times; combs stay inline.

Verification
REQ-031 Reset: rst_n=0 during activity -> all outputs 0 asynchronously; after release, no valid_out before 4 valid_in with dec_sel=2.
REQ-032 DC: dec_sel=2, gain_sel=0, cic_in=0x4000 continuous -> valid_out every 4th valid_in, cic_out=0x4000 from the 6th output onward, flags 0.
REQ-033 Saturation: dec_sel=1, gain_sel=2, cic_in=0x4000 -> settled cic_out=0x7FFF with overflow=1; cic_in=0xC000 -> 0x8000 with underflow=1.
REQ-034 Bypass: bypass=1, cic_in=0x1234 with valid_in -> next cycle cic_out=0x1234, valid_out=1 per input.
REQ-035 Rate change: dec_sel 2->3 mid-stream -> state cleared, next valid_out exactly after 8 accepted valid_in (change cycle excluded).
REQ-036 Rounding: dec_sel=1, single impulse 0x0001 then zeros -> outputs match golden model with/without CIC_ROUND_EN (bit-exact).
